// File: rtl/red_pitaya_hk_gpio_if.sv
// System bus bundle between the housekeeping bus master and the GPIO block.
// Latency: n/a (wires only).
// Backpressure: none; the slave acks every access one cycle after the strobe.
//
// Signals:
//   sys_addr / sys_wdata  - byte address and write data from the master
//   sys_wen / sys_ren     - single-cycle write / read strobes
//   sys_rdata             - read data, valid in the ack cycle
//   sys_err / sys_ack     - error flag (always 0) and access acknowledge
interface red_pitaya_hk_gpio_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/red_pitaya_hk_gpio.sv
// Banked GPIO with input sync, optional debounce, edge-latched status and IRQ.
// Latency: bus ack/rdata 1 cycle after strobe; pin edge -> STATUS in SYNC+2 cycles, irq_o +1.
// Backpressure: none; every access is accepted and acked the following cycle.
//
// Ports:
//   clk_i, rstn_i - single clock, asynchronous active-low reset
//   gpio_dat_i    - asynchronous pin inputs, bank b at [b*DW +: DW]
//   gpio_dat_o    - DAT_O registers, gpio_dir_o - DIR registers (1 = drive)
//   irq_o         - registered level interrupt (IRQ_EN & any masked status)
//   sys           - system bus slave
module red_pitaya_hk_gpio #(
    parameter int DW   = 8,
    parameter int NB   = 2,
    parameter int SYNC = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [NB*DW-1:0]     gpio_dat_i,
    output logic [NB*DW-1:0]     gpio_dat_o,
    output logic [NB*DW-1:0]     gpio_dir_o,
    output logic                 irq_o,
    red_pitaya_hk_gpio_if.slave  sys
);

    localparam int W = NB * DW;

    localparam logic [4:0]  OFF_DIR      = 5'h00;
    localparam logic [4:0]  OFF_DAT_O    = 5'h04;
    localparam logic [4:0]  OFF_DAT_I    = 5'h08;
    localparam logic [4:0]  OFF_RISE_EN  = 5'h0C;
    localparam logic [4:0]  OFF_FALL_EN  = 5'h10;
    localparam logic [4:0]  OFF_STATUS   = 5'h14;
    localparam logic [4:0]  OFF_MASK     = 5'h18;
    localparam logic [19:0] ADR_DEB_LEN  = 20'h00100;
    localparam logic [19:0] ADR_IRQ_EN   = 20'h00104;
    localparam logic [19:0] ADR_IRQ_PEND = 20'h00108;

    // Bank registers
    logic [NB-1:0][DW-1:0] dir_r;
    logic [NB-1:0][DW-1:0] dat_o_r;
    logic [NB-1:0][DW-1:0] rise_en_r;
    logic [NB-1:0][DW-1:0] fall_en_r;
    logic [NB-1:0][DW-1:0] status_r;
    logic [NB-1:0][DW-1:0] mask_r;

    // Global registers
    logic [15:0] deb_len_r;
    logic        irq_en_r;

    // Bus decode
    logic [19:0]   adr;
    logic          bank_space;
    logic [2:0]    adr_bank;
    logic [4:0]    adr_off;
    logic [DW-1:0] wdat;
    logic [NB-1:0] bank_hit;
    logic          deb_len_we;

    assign adr        = sys.sys_addr[19:0];
    assign bank_space = (adr[19:8] == 12'h000);
    assign adr_bank   = adr[7:5];
    assign adr_off    = adr[4:0];
    assign wdat       = sys.sys_wdata[DW-1:0];
    assign deb_len_we = sys.sys_wen && (adr == ADR_DEB_LEN);

    always_comb begin
        bank_hit = '0;
        for (int b = 0; b < NB; b++) begin
            bank_hit[b] = bank_space && (adr_bank == 3'(b));
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, sys.sys_addr[31:20], sys.sys_wdata};

    // Input synchroniser; stage 0 takes the raw pins
    logic [SYNC-1:0][W-1:0] sync_r;
    logic [W-1:0]           sync_out;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC-2:0], gpio_dat_i};
        end
    end

    assign sync_out = sync_r[SYNC-1];

    // Debounce: one prescaler shared by all pins. A pin's debounced value only
    // moves when two consecutive tick samples agree.
    logic [15:0]           pre_cnt;
    logic                  tick;
    logic [W-1:0]          smp_prev;
    logic [NB-1:0][DW-1:0] deb_r;
    logic [NB-1:0][DW-1:0] deb_d;
    logic [W-1:0]          smp_diff;

    assign tick     = (deb_len_r != 16'd0) && (pre_cnt == deb_len_r);
    assign smp_diff = sync_out ^ smp_prev;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pre_cnt  <= '0;
            smp_prev <= '0;
            deb_r    <= '0;
            deb_d    <= '0;
        end else begin
            deb_d <= deb_r;
            if (deb_len_we) begin
                // restart the sampling window so a new length starts cleanly
                pre_cnt  <= '0;
                smp_prev <= '0;
            end else if (deb_len_r == 16'd0) begin
                pre_cnt <= '0;
            end else if (tick) begin
                pre_cnt  <= '0;
                smp_prev <= sync_out;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end

            if (deb_len_r == 16'd0) begin
                deb_r <= sync_out;
            end else if (tick && !deb_len_we) begin
                deb_r <= (sync_out & ~smp_diff) | (deb_r & smp_diff);
            end
        end
    end

    // Edge detection on the debounced value. Edges are single-cycle pulses,
    // so enabling a RISE/FALL bit later never fires on old state.
    logic [NB-1:0][DW-1:0] rise;
    logic [NB-1:0][DW-1:0] fall;
    logic [NB-1:0][DW-1:0] status_clr;

    assign rise = deb_r & ~deb_d;
    assign fall = ~deb_r & deb_d;

    always_comb begin
        status_clr = '0;
        for (int b = 0; b < NB; b++) begin
            if (sys.sys_wen && bank_hit[b] && (adr_off == OFF_STATUS)) begin
                status_clr[b] = wdat;
            end
        end
    end

    // A new edge in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            status_r <= '0;
        end else begin
            status_r <= (status_r & ~status_clr) | (rise & rise_en_r) | (fall & fall_en_r);
        end
    end

    // Register writes
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dir_r     <= '0;
            dat_o_r   <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
            mask_r    <= '0;
            deb_len_r <= '0;
            irq_en_r  <= 1'b0;
        end else if (sys.sys_wen) begin
            for (int b = 0; b < NB; b++) begin
                if (bank_hit[b]) begin
                    case (adr_off)
                        OFF_DIR:     dir_r[b]     <= wdat;
                        OFF_DAT_O:   dat_o_r[b]   <= wdat;
                        OFF_RISE_EN: rise_en_r[b] <= wdat;
                        OFF_FALL_EN: fall_en_r[b] <= wdat;
                        OFF_MASK:    mask_r[b]    <= wdat;
                        default: ;
                    endcase
                end
            end
            if (adr == ADR_DEB_LEN) begin
                deb_len_r <= sys.sys_wdata[15:0];
            end
            if (adr == ADR_IRQ_EN) begin
                irq_en_r <= sys.sys_wdata[0];
            end
        end
    end

    // Interrupt
    logic [7:0] irq_pend;

    always_comb begin
        irq_pend = '0;
        for (int b = 0; b < NB; b++) begin
            irq_pend[b] = |(status_r[b] & mask_r[b]);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= irq_en_r & (|irq_pend);
        end
    end

    // Read mux
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        for (int b = 0; b < NB; b++) begin
            if (bank_hit[b]) begin
                case (adr_off)
                    OFF_DIR:     rd_val = 32'(dir_r[b]);
                    OFF_DAT_O:   rd_val = 32'(dat_o_r[b]);
                    OFF_DAT_I:   rd_val = 32'(deb_r[b]);
                    OFF_RISE_EN: rd_val = 32'(rise_en_r[b]);
                    OFF_FALL_EN: rd_val = 32'(fall_en_r[b]);
                    OFF_STATUS:  rd_val = 32'(status_r[b]);
                    OFF_MASK:    rd_val = 32'(mask_r[b]);
                    default: ;
                endcase
            end
        end
        case (adr)
            ADR_DEB_LEN:  rd_val = 32'(deb_len_r);
            ADR_IRQ_EN:   rd_val = 32'(irq_en_r);
            ADR_IRQ_PEND: rd_val = 32'(irq_pend);
            default: ;
        endcase
    end

    // Bus response
    logic        ack_r;
    logic [31:0] rdata_r;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_r   <= 1'b0;
            rdata_r <= '0;
        end else begin
            ack_r   <= sys.sys_wen | sys.sys_ren;
            rdata_r <= sys.sys_ren ? rd_val : 32'h0;
        end
    end

    assign sys.sys_ack   = ack_r;
    assign sys.sys_rdata = rdata_r;
    assign sys.sys_err   = 1'b0;

    assign gpio_dat_o = dat_o_r;
    assign gpio_dir_o = dir_r;

endmodule

// File: tb/tb_red_pitaya_hk_gpio.sv
// Directed bench for red_pitaya_hk_gpio (DW=8, NB=2, SYNC=2).
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Each scenario task compares against hand-computed values.
module tb_red_pitaya_hk_gpio;

    logic        clk;
    logic        rstn;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_dir;
    logic        irq;

    int checks;
    int failures;

    red_pitaya_hk_gpio_if bus ();

    red_pitaya_hk_gpio #(.DW(8), .NB(2), .SYNC(2)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .gpio_dat_i (gpio_in),
        .gpio_dat_o (gpio_out),
        .gpio_dir_o (gpio_dir),
        .irq_o      (irq),
        .sys        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sys_addr  = a;
        bus.sys_wdata = d;
        bus.sys_wen   = 1'b1;
        @(negedge clk);
        bus.sys_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ack);
        @(negedge clk);
        bus.sys_addr = a;
        bus.sys_ren  = 1'b1;
        @(negedge clk);
        bus.sys_ren  = 1'b0;
        d   = bus.sys_rdata;
        ack = bus.sys_ack;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        a;
        rstn = 1'b0;
        wait_cyc(3);
        checks++;
        if ({gpio_out, gpio_dir, irq, bus.sys_ack, bus.sys_err} !== 35'h0) begin
            failures++;
            $display("FAIL reset_outputs: dat_o=%h dir_o=%h irq=%b ack=%b err=%b expected all 0",
                     gpio_out, gpio_dir, irq, bus.sys_ack, bus.sys_err);
        end
        checks++;
        if (bus.sys_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 0", bus.sys_rdata);
        end
        rstn = 1'b1;
        bus_read(32'h100, d, a);
        checks++;
        if (d !== 32'h0 || a !== 1'b1) begin
            failures++;
            $display("FAIL reset_deb_len: rdata=%h ack=%b expected 0 ack 1", d, a);
        end
    endtask

    task automatic test_regs;
        logic [31:0] d;
        logic        a;
        bus_write(32'h04, 32'hA5);
        checks++;
        if (gpio_out !== 16'h00A5) begin
            failures++;
            $display("FAIL dat_o_update: got %h expected 00a5", gpio_out);
        end
        bus_write(32'h00, 32'hFF);
        checks++;
        if (gpio_dir !== 16'h00FF) begin
            failures++;
            $display("FAIL dir_o_update: got %h expected 00ff", gpio_dir);
        end
        bus_read(32'h04, d, a);
        checks++;
        if (d !== 32'hA5 || a !== 1'b1) begin
            failures++;
            $display("FAIL read_dat_o: rdata=%h ack=%b expected a5 ack 1", d, a);
        end
        @(negedge clk);
        checks++;
        if (bus.sys_ack !== 1'b0) begin
            failures++;
            $display("FAIL ack_single: ack=%b expected 0 one cycle after ack", bus.sys_ack);
        end
        bus_read(32'h00, d, a);
        checks++;
        if (d !== 32'hFF || a !== 1'b1) begin
            failures++;
            $display("FAIL read_dir: rdata=%h ack=%b expected ff ack 1", d, a);
        end
        bus_write(32'h08, 32'hFF);
        bus_read(32'h08, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL dat_i_ro: got %h expected 0", d);
        end
        bus_write(32'h100, 32'h12345);
        bus_read(32'h100, d, a);
        checks++;
        if (d !== 32'h2345) begin
            failures++;
            $display("FAIL deb_len_width: got %h expected 2345", d);
        end
        bus_write(32'h100, 32'h0);
        bus_write(32'h104, 32'hFFFFFFFF);
        bus_read(32'h104, d, a);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL irq_en_width: got %h expected 1", d);
        end
        bus_write(32'h108, 32'hFF);
        bus_read(32'h108, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL irq_pend_ro: got %h expected 0", d);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.sys_addr = 32'h00;
        bus.sys_ren  = 1'b1;
        @(negedge clk);
        bus.sys_addr = 32'h04;
        checks++;
        if (bus.sys_rdata !== 32'hFF || bus.sys_ack !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: rdata=%h ack=%b expected ff ack 1", bus.sys_rdata, bus.sys_ack);
        end
        @(negedge clk);
        bus.sys_ren = 1'b0;
        checks++;
        if (bus.sys_rdata !== 32'hA5 || bus.sys_ack !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: rdata=%h ack=%b expected a5 ack 1", bus.sys_rdata, bus.sys_ack);
        end
        @(negedge clk);
        checks++;
        if (bus.sys_ack !== 1'b0 || bus.sys_rdata !== 32'h0) begin
            failures++;
            $display("FAIL b2b_idle: rdata=%h ack=%b expected 0 ack 0", bus.sys_rdata, bus.sys_ack);
        end
    endtask

    task automatic test_rise_irq;
        logic [31:0] d;
        logic        a;
        bus_write(32'h0C, 32'h08);
        bus_write(32'h18, 32'h08);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        wait_cyc(4);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL rise_irq_early: irq=%b expected 0 at SYNC+2", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL rise_irq: irq=%b expected 1 at SYNC+3", irq);
        end
        bus_read(32'h14, d, a);
        checks++;
        if (d !== 32'h08) begin
            failures++;
            $display("FAIL rise_status: got %h expected 08", d);
        end
        bus_write(32'h14, 32'h08);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_irq_lag: irq=%b expected 1 in write ack cycle", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_irq_low: irq=%b expected 0", irq);
        end
        bus_read(32'h14, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL w1c_status: got %h expected 0", d);
        end
    endtask

    task automatic test_w1c_collision;
        logic [31:0] d;
        logic        a;
        bus_write(32'h10, 32'h08);
        @(negedge clk);
        gpio_in[3] = 1'b0;
        wait_cyc(6);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL fall_irq: irq=%b expected 1", irq);
        end
        @(negedge clk);
        gpio_in[3] = 1'b1;
        wait_cyc(3);
        bus.sys_addr  = 32'h14;
        bus.sys_wdata = 32'h08;
        bus.sys_wen   = 1'b1;
        @(negedge clk);
        bus.sys_wen = 1'b0;
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL collide_irq: irq=%b expected 1", irq);
        end
        bus_read(32'h14, d, a);
        checks++;
        if (d !== 32'h08) begin
            failures++;
            $display("FAIL collide_status: got %h expected 08", d);
        end
    endtask

    task automatic test_bank1_mask;
        logic [31:0] d;
        logic        a;
        bus_write(32'h14, 32'hFF);
        bus_write(32'h30, 32'h80);
        bus_write(32'h38, 32'h00);
        gpio_in[15] = 1'b1;
        wait_cyc(6);
        gpio_in[15] = 1'b0;
        wait_cyc(6);
        bus_read(32'h34, d, a);
        checks++;
        if (d !== 32'h80) begin
            failures++;
            $display("FAIL bank1_status: got %h expected 80", d);
        end
        bus_read(32'h108, d, a);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL bank1_masked: pend=%h irq=%b expected 0 irq 0", d, irq);
        end
        bus_write(32'h38, 32'h80);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL bank1_irq: irq=%b expected 1", irq);
        end
        bus_read(32'h108, d, a);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("FAIL bank1_pend: got %h expected 2", d);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        logic        a;
        bus_read(32'h200, d, a);
        checks++;
        if (d !== 32'h0 || a !== 1'b1 || bus.sys_err !== 1'b0) begin
            failures++;
            $display("FAIL unmapped_200: rdata=%h ack=%b err=%b expected 0 1 0", d, a, bus.sys_err);
        end
        bus_write(32'h40, 32'hFF);
        bus_read(32'h40, d, a);
        checks++;
        if (d !== 32'h0 || a !== 1'b1) begin
            failures++;
            $display("FAIL bank2_dir: rdata=%h ack=%b expected 0 ack 1", d, a);
        end
        bus_read(32'h1C, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_1c: got %h expected 0", d);
        end
        bus_read(32'h0010_0000, d, a);
        checks++;
        if (d !== 32'hFF) begin
            failures++;
            $display("FAIL addr_alias: got %h expected ff", d);
        end
    endtask

    task automatic test_debounce;
        logic [31:0] d;
        logic        a;
        bus_write(32'h14, 32'hFF);
        bus_write(32'h0C, 32'h01);
        bus_write(32'h100, 32'h4);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        wait_cyc(3);
        gpio_in[0] = 1'b0;
        wait_cyc(20);
        bus_read(32'h08, d, a);
        checks++;
        if (d !== 32'h08) begin
            failures++;
            $display("FAIL glitch_dat_i: got %h expected 08", d);
        end
        bus_read(32'h14, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL glitch_status: got %h expected 0", d);
        end
        @(negedge clk);
        gpio_in[0] = 1'b1;
        wait_cyc(15);
        bus_read(32'h08, d, a);
        checks++;
        if (d !== 32'h09) begin
            failures++;
            $display("FAIL held_dat_i: got %h expected 09", d);
        end
        bus_read(32'h14, d, a);
        checks++;
        if (d !== 32'h01) begin
            failures++;
            $display("FAIL held_status: got %h expected 01", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic        a;
        @(negedge clk);
        bus.sys_addr = 32'h04;
        bus.sys_ren  = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({gpio_out, gpio_dir, irq, bus.sys_ack, bus.sys_err} !== 35'h0 || bus.sys_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_async: dat_o=%h dir_o=%h irq=%b ack=%b rdata=%h expected all 0",
                     gpio_out, gpio_dir, irq, bus.sys_ack, bus.sys_rdata);
        end
        @(negedge clk);
        bus.sys_ren = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.sys_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_ack: ack=%b expected 0", bus.sys_ack);
        end
        wait_cyc(6);
        bus_read(32'h14, d, a);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_no_event: status=%h expected 0", d);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rstn          = 1'b0;
        gpio_in       = '0;
        bus.sys_addr  = '0;
        bus.sys_wdata = '0;
        bus.sys_wen   = 1'b0;
        bus.sys_ren   = 1'b0;

        test_reset();
        test_regs();
        test_back_to_back();
        test_rise_irq();
        test_w1c_collision();
        test_bank1_mask();
        test_unmapped();
        test_debounce();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/red_pitaya_hk_gpio.md
RED_PITAYA_HK_GPIO -- requirements
Module: red_pitaya_hk_gpio

Interface
REQ-001 SHALL have parameter DW, default 8, pins per bank (1..32).
REQ-002 SHALL have parameter NB, default 2, number of banks (1..8); bank 0 = exp_p, bank 1 = exp_n.
REQ-003 SHALL have parameter SYNC, default 2, input synchroniser stages (>=2).
REQ-004 SHALL have port clk_i  in  1  system clock; all logic in this single domain.
REQ-005 SHALL have port rstn_i  in  1  reset, asynchronous, active low.
REQ-006 SHALL have port gpio_dat_i  in  NB*DW  pin inputs, async; bank b at bits [b*DW +: DW].
REQ-007 SHALL have port gpio_dat_o  out  NB*DW  pin output data.
REQ-008 SHALL have port gpio_dir_o  out  NB*DW  per-pin output enable, 1 = drive.
REQ-009 SHALL have port irq_o  out  1  registered level interrupt.
REQ-010 SHALL have ports sys_addr in 32, sys_wdata in 32, sys_wen in 1, sys_ren in 1, sys_rdata out 32, sys_err out 1, sys_ack out 1: system bus.

Function
REQ-011 SHALL decode sys_addr[19:0]; bank b registers at 0x20*b + offset: 0x00 DIR, 0x04 DAT_O, 0x08 DAT_I (RO), 0x0C RISE_EN, 0x10 FALL_EN, 0x14 STATUS (W1C), 0x18 MASK.
REQ-012 SHALL provide globals: 0x100 DEB_LEN (16 bit RW), 0x104 IRQ_EN (bit 0 RW), 0x108 IRQ_PEND (RO, bit b = bank b has |(STATUS&MASK)).
REQ-013 SHALL assert sys_ack exactly one cycle after any cycle with sys_wen|sys_ren, for every address; sys_err SHALL stay 0.
REQ-014 SHALL register sys_rdata in the ack cycle; registers narrower than 32 bits zero-extended; unmapped addresses and banks >= NB read 0, writes ignored.
REQ-015 SHALL ignore writes to DAT_I and IRQ_PEND; only bits [DW-1:0] of sys_wdata used for bank registers.
REQ-016 SHALL pass each gpio_dat_i bit through SYNC flops before any other use.
REQ-017 Debounce, DEB_LEN==0: debounced value SHALL equal synchroniser output, one extra register stage.
REQ-018 Debounce, DEB_LEN=N>0: shared prescaler counts 0..N, tick when count==N then wraps to 0; on tick each pin sampled; debounced bit SHALL update only when the current and previous tick samples are equal.
REQ-019 Writing DEB_LEN SHALL clear the prescaler and previous-sample register in the same cycle.
REQ-020 DAT_I SHALL read the debounced value.
REQ-021 Rising edge = debounced 1 with previous-cycle debounced 0; falling edge the converse; STATUS bit SHALL set on an edge whose RISE_EN/FALL_EN bit is 1.
REQ-022 STATUS bit SHALL clear on write of 1 to that bit; a set event in the same cycle SHALL win (bit remains 1).
REQ-023 MASK SHALL not affect STATUS latching, only IRQ_PEND and irq_o.
REQ-024 irq_o SHALL be IRQ_EN & |IRQ_PEND, registered, one cycle after STATUS/MASK/IRQ_EN change.
REQ-025 gpio_dat_o and gpio_dir_o SHALL be the DAT_O and DIR registers directly, updated the cycle after the write.
REQ-026 Enabling an edge bit SHALL not generate an event from historical state; only edges after enable count.

Reset
REQ-027 On rstn_i low, asynchronously: DIR, DAT_O, RISE_EN, FALL_EN, STATUS, MASK, DEB_LEN, IRQ_EN, prescaler, synchroniser, debounce and edge-history registers = 0; irq_o, sys_ack, sys_err, sys_rdata = 0.
REQ-028 Reset released mid-bus-access SHALL drop the pending ack; no spurious ack after release.
REQ-029 After release, pins already high SHALL produce a rising-edge event only if RISE_EN is set before the synchronised 1 arrives.

Verification
REQ-030 Write 0xA5 to 0x04, 0xFF to 0x00 -> gpio_dat_o[7:0]=0xA5, gpio_dir_o[7:0]=0xFF next cycle; reads return same with ack one cycle after ren.
REQ-031 DEB_LEN=0, RISE_EN[3]=1, MASK[3]=1, IRQ_EN=1, pin 3 0->1 -> STATUS=0x08 after SYNC+2 cycles, irq_o 1 cycle later; write 0x08 to 0x14 -> STATUS 0, irq_o low next cycle.
REQ-032 DEB_LEN=4, 3-cycle glitch on pin 0 -> DAT_I bit 0 unchanged, no STATUS; pulse held 15 cycles -> DAT_I bit 0 = 1.
REQ-033 W1C of STATUS in the same cycle as new enabled edge on that bit -> STATUS bit stays 1, irq_o stays 1.
REQ-034 Bank 1 FALL_EN[7]=1, MASK=0, pin 15 1->0 -> 0x34 STATUS=0x80, 0x108 reads 0, irq_o 0; set MASK[7] -> 0x108 reads 0x2, irq_o 1.
REQ-035 Read 0x200 and bank 2 (NB=2) -> ack next cycle, rdata 0, sys_err 0; assert rstn_i during pending access -> all outputs 0 immediately.
